spi_ram_responder: RTL

//   SPI-mode-0 slave that emulates a 23LC-style serial SRAM behind a 16-bit address. Sits on the
//   far side of the SPI RAM master's bus: as an on-chip RAM target, or as a bench model for it.

---
 rtl/spi_ram_responder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_ram_responder.sv
// SPI mode-0 serial-SRAM target (READ/WRITE/RDMR), all pins oversampled on clk, no SCK-clocked logic.
// Latency: MISO updates 3 clk after a raw SCK fall; wr_strobe 3 clk after the 8th rise. No backpressure: SCK phases >= 4 clk.
module spi_ram_responder #(
  parameter int         ADDR_W   = 10,
  parameter logic [7:0] MODE_REG = 8'h40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCK,
  input  logic              CS_N,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  output logic              busy,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int RX_W  = (ADDR_W > 8) ? ADDR_W : 8;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, STATUS, IGNORE} state_t;
  state_t r_state, w_state_nxt;

  logic [1:0]        r_sck_s, r_cs_s, r_mosi_s;
  logic              r_sck_d, r_cs_d;
  logic              w_rise, w_fall, w_cs_fall, w_cs_rise;
  logic [3:0]        r_bitcnt;
  logic              w_bit_last;
  logic [RX_W-2:0]   r_rx;
  logic [RX_W-1:0]   w_rx_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd;
  logic [7:0]        r_tx;
  logic              r_miso, r_oe, r_busy;
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_load1, r_load2;
  logic [7:0]        r_ram_q;
  logic              w_wr_en;
  logic [7:0]        r_mem [0:DEPTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sck_s  <= 2'b00;
      r_cs_s   <= 2'b11;
      r_mosi_s <= 2'b00;
      r_sck_d  <= 1'b0;
      r_cs_d   <= 1'b1;
    end else begin
      r_sck_s  <= {r_sck_s[0], SCK};
      r_cs_s   <= {r_cs_s[0], CS_N};
      r_mosi_s <= {r_mosi_s[0], MOSI};
      r_sck_d  <= r_sck_s[1];
      r_cs_d   <= r_cs_s[1];
    end
  end

  assign w_rise     = r_sck_s[1] & ~r_sck_d;
  assign w_fall     = ~r_sck_s[1] & r_sck_d;
  assign w_cs_fall  = r_cs_d & ~r_cs_s[1];
  assign w_cs_rise  = ~r_cs_d & r_cs_s[1];
  assign w_rx_nxt   = {r_rx, r_mosi_s[1]};
  assign w_bit_last = (r_state == ADDR) ? (r_bitcnt == 4'd15) : (r_bitcnt[2:0] == 3'd7);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // CS_N rise wins over any SCK edge seen in the same clk.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    if (w_cs_rise) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (w_cs_fall) w_state_nxt = CMD;
        CMD: begin
          if (w_rise && w_bit_last) begin
            case (w_rx_nxt[7:0])
              8'h03, 8'h02: w_state_nxt = ADDR;
              8'h05:        w_state_nxt = STATUS;
              default:      w_state_nxt = IGNORE;
            endcase
          end
        end
        ADDR:  if (w_rise && w_bit_last) w_state_nxt = r_rd ? RDATA : WDATA;
        WDATA: if (w_rise && w_bit_last) w_wr_en = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bitcnt    <= '0;
      r_rx        <= '0;
      r_addr      <= '0;
      r_rd        <= 1'b0;
      r_tx        <= '0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_load1     <= 1'b0;
      r_load2     <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_load1     <= 1'b0;
      r_load2     <= r_load1;
      r_busy      <= ~r_cs_s[1];
      r_oe        <= (w_state_nxt == RDATA) || (w_state_nxt == STATUS);
      if (w_cs_rise || r_state == IDLE) begin
        r_bitcnt <= '0;
      end else if (w_rise) begin
        r_rx     <= w_rx_nxt[RX_W-2:0];
        r_bitcnt <= w_bit_last ? 4'd0 : r_bitcnt + 4'd1;
        if (w_bit_last) begin
          case (r_state)
            CMD: begin
              r_rd <= (w_rx_nxt[7:0] == 8'h03);
              if (w_rx_nxt[7:0] == 8'h05) r_tx <= MODE_REG;
            end
            ADDR: begin
              r_addr  <= w_rx_nxt[ADDR_W-1:0];
              r_load1 <= r_rd;
            end
            WDATA: begin
              r_wr_strobe <= 1'b1;
              r_wr_addr   <= r_addr;
              r_wr_data   <= w_rx_nxt[7:0];
              r_addr      <= r_addr + ADDR_W'(1);
            end
            RDATA: begin
              r_addr  <= r_addr + ADDR_W'(1);
              r_load1 <= 1'b1;
            end
            STATUS: r_tx <= MODE_REG;
            default: ;
          endcase
        end
      end else if (w_fall && (r_state == RDATA || r_state == STATUS)) begin
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end
      // RAM read lands two clk after the address moves, well before the next SCK fall.
      if (r_load2) r_tx <= r_ram_q;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_addr] <= w_rx_nxt[7:0];
    r_ram_q <= r_mem[r_addr];
  end

  assign MISO      = r_miso;
  assign MISO_OE   = r_oe;
  assign busy      = r_busy;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
endmodule
